// File: rtl/fifo_vr_wm_if.sv
// rtl/fifo_vr_wm_if.sv - valid/ready write and read channels of fifo_vr_wm
interface fifo_vr_wm_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  // producer + consumer side (drives writes, accepts reads)
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  // FIFO side
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/fifo_vr_wm.sv
// rtl/fifo_vr_wm.sv - valid/ready FIFO with count, free, threshold flags and watermark; optional FIFO_BYPASS_EN
module fifo_vr_wm #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  fifo_vr_wm_if.slave          bus,
  input  logic [CNT_WIDTH-1:0] af_level_i,
  input  logic [CNT_WIDTH-1:0] ae_level_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [CNT_WIDTH-1:0] free_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 afull_o,
  output logic                 aempty_o,
  output logic [CNT_WIDTH-1:0] max_cnt_o
);

  localparam int                   PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic [CNT_WIDTH-1:0]  max_cnt;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_en;

  assign full_o  = (count == DEPTH_CNT);
  assign empty_o = (count == '0);

  // in_ready depends on state only, so a full FIFO refuses a write even when a pop happens
  assign bus.in_ready_o = !full_o;

  assign push = bus.in_valid_i & bus.in_ready_o;
  assign pop  = bus.out_valid_o & bus.out_ready_i;

`ifdef FIFO_BYPASS_EN
  logic bypass;

  // an empty FIFO presents the incoming word directly to the consumer
  assign bypass          = empty_o & bus.in_valid_i;
  assign bus.out_valid_o = !empty_o | bus.in_valid_i;
  assign bus.out_data_o  = bypass ? bus.in_data_i : mem[rd_ptr];

  // a word that passes straight through is never stored and never read from storage
  assign wr_en = push & !(bypass & bus.out_ready_i);
  assign rd_en = pop & !empty_o;
`else
  assign bus.out_valid_o = !empty_o;
  assign bus.out_data_o  = mem[rd_ptr];

  assign wr_en = push;
  assign rd_en = pop;
`endif

  // next occupancy: a simultaneous write and read leaves it unchanged
  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CNT_WIDTH'(1);
      2'b01:   count_nxt = count - CNT_WIDTH'(1);
      default: count_nxt = count;
    endcase
  end

  // storage is not reset; a write in a flush cycle is dropped
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && wr_en) begin
      mem[wr_ptr] <= bus.in_data_i;
    end
  end

  // pointers, count and watermark; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      max_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end
      count <= count_nxt;
      if (count_nxt > max_cnt) begin
        max_cnt <= count_nxt;
      end
    end
  end

  // status outputs; thresholds act on the live level inputs
  assign count_o   = count;
  assign free_o    = DEPTH_CNT - count;
  assign max_cnt_o = max_cnt;
  assign afull_o   = (count >= af_level_i);
  assign aempty_o  = (count <= ae_level_i);

endmodule

// File: tb/tb_fifo_vr_wm.sv
// tb/tb_fifo_vr_wm.sv - scoreboard bench for fifo_vr_wm
module tb_fifo_vr_wm;
  localparam int DW    = 32;
  localparam int DEPTH = 6;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] af_level;
  logic [CW-1:0] ae_level;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic [CW-1:0] max_cnt;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb_q[$];
  int            max_exp = 0;

  fifo_vr_wm_if #(.DATA_WIDTH(DW)) bif ();

  fifo_vr_wm #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .bus        (bif),
    .af_level_i (af_level),
    .ae_level_i (ae_level),
    .count_o    (count),
    .free_o     (free),
    .full_o     (full),
    .empty_o    (empty),
    .afull_o    (afull),
    .aempty_o   (aempty),
    .max_cnt_o  (max_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(sb_q.size()));
    check("free", 32'(free), 32'(DEPTH - sb_q.size()));
    check("max_cnt", 32'(max_cnt), 32'(max_exp));
    check("empty", 32'(empty), 32'(sb_q.size() == 0));
    check("full", 32'(full), 32'(sb_q.size() == DEPTH));
    check("afull", 32'(afull), 32'(sb_q.size() >= int'(af_level)));
    check("aempty", 32'(aempty), 32'(sb_q.size() <= int'(ae_level)));
  endtask

  // one clock: drive, check handshake outputs on the falling edge, update model, check after the edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic          exp_ready;
    logic          exp_valid;
    logic          byp;
    logic [DW-1:0] exp_data;
    bif.in_valid_i  = v;
    bif.in_data_i   = d;
    bif.out_ready_i = r;
    flush           = f;
    @(negedge clk);
    exp_ready = (sb_q.size() < DEPTH);
`ifdef FIFO_BYPASS_EN
    byp = (sb_q.size() == 0) && v;
`else
    byp = 1'b0;
`endif
    exp_valid = (sb_q.size() > 0) || byp;
    check("in_ready", 32'(bif.in_ready_o), 32'(exp_ready));
    check("out_valid", 32'(bif.out_valid_o), 32'(exp_valid));
    if (exp_valid && r) begin
      if (sb_q.size() > 0) exp_data = sb_q.pop_front();
      else exp_data = d;
      if (!f) check("out_data", bif.out_data_o, exp_data);
    end
    if (v && exp_ready && !(byp && r)) sb_q.push_back(d);
    if (f) begin
      sb_q.delete();
      max_exp = 0;
    end else if (sb_q.size() > max_exp) begin
      max_exp = sb_q.size();
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    af_level        = 3'd4;
    ae_level        = 3'd1;
    bif.in_valid_i  = 1'b0;
    bif.in_data_i   = '0;
    bif.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(bif.in_ready_o), 32'd1);
    check("rst_out_valid", 32'(bif.out_valid_o), 32'd0);
    check_state();

    // fill 0xA0..0xA5 with no reader; flags are checked at every count
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_max", 32'(max_cnt), 32'd6);
    check("fill_free", 32'(free), 32'd0);

    // threshold extremes act immediately
    af_level = 3'd0;
    #1 check("af0_afull", 32'(afull), 32'd1);
    af_level = 3'd7;
    #1 check("af7_afull", 32'(afull), 32'd0);
    af_level = 3'd4;
    #1;

    // full with both sides active: pop only, then the push goes in
    step(1'b1, 32'hB0, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 32'd5);
    step(1'b1, 32'hB0, 1'b0, 1'b0);
    check("fullpop_refill", 32'(count), 32'd6);

    // drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);

    // wrap: hold count at 3 while streaming through the pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(32'hD0 + i), 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // flush at count 4 with push and pop in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'hE0 + i), 1'b0, 1'b0);
    step(1'b1, 32'hEE, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_max", 32'(max_cnt), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // empty FIFO, write and read together
    step(1'b1, 32'h5A, 1'b1, 1'b0);
`ifdef FIFO_BYPASS_EN
    check("bypass_count", 32'(count), 32'd0);
`else
    check("nobypass_count", 32'(count), 32'd1);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    check("bypass_end_count", 32'(count), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
